// File: rtl/key_debounce_multi.sv
// N-channel push-button conditioner: per-key 2-flop synchroniser, debounce FSM,
// press/release/long-press pulses and a press-toggled LED.
`timescale 1ns/1ps

module key_debounce_multi #(
   parameter int N_KEYS       = 4,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int LONG_CYC     = 50_000_000,
   parameter bit ACTIVE_LOW   = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_state,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_long,
   output logic [N_KEYS-1:0] led
);

   localparam int DW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int HW = $clog2(LONG_CYC + 1);

   // The debounce counter starts at 0 on the first qualifying sample, so the
   // final qualifying sample is the one seen while it holds DEBOUNCE_CYC-2.
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 2);
   localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYC);
   localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYC - 1);
   localparam logic [N_KEYS-1:0] RELEASED_LEVEL = ACTIVE_LOW ? '1 : '0;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_F,
      DOWN,
      REL_F
   } state_t;

   logic [N_KEYS-1:0] sync_1;
   logic [N_KEYS-1:0] sync_2;
   logic [N_KEYS-1:0] pressed;

   state_t            state    [N_KEYS];
   logic   [DW-1:0]   db_cnt   [N_KEYS];
   logic   [HW-1:0]   hold_cnt [N_KEYS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= RELEASED_LEVEL;
         sync_2 <= RELEASED_LEVEL;
      end else begin
         sync_1 <= key_in;
         sync_2 <= sync_1;
      end
   end

   assign pressed = ACTIVE_LOW ? ~sync_2 : sync_2;

   // Hold count survives a release bounce, so a key that chatters while held
   // keeps its place toward key_long and cannot earn a second long pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_KEYS; i++) begin
            state[i]    <= IDLE;
            db_cnt[i]   <= '0;
            hold_cnt[i] <= '0;
         end
         key_state   <= '0;
         key_press   <= '0;
         key_release <= '0;
         key_long    <= '0;
         led         <= '0;
      end else begin
         key_press   <= '0;
         key_release <= '0;
         key_long    <= '0;
         for (int i = 0; i < N_KEYS; i++) begin
            case (state[i])
               IDLE: begin
                  if (pressed[i]) begin
                     state[i]  <= PRESS_F;
                     db_cnt[i] <= '0;
                  end
               end
               PRESS_F: begin
                  if (!pressed[i]) begin
                     state[i] <= IDLE;
                  end else if (db_cnt[i] == DB_LAST) begin
                     state[i]     <= DOWN;
                     db_cnt[i]    <= '0;
                     hold_cnt[i]  <= '0;
                     key_state[i] <= 1'b1;
                     key_press[i] <= 1'b1;
                     led[i]       <= ~led[i];
                  end else begin
                     db_cnt[i] <= db_cnt[i] + DW'(1);
                  end
               end
               DOWN: begin
                  if (pressed[i]) begin
                     if (hold_cnt[i] != HOLD_MAX) begin
                        hold_cnt[i] <= hold_cnt[i] + HW'(1);
                     end
                     if (hold_cnt[i] == HOLD_PRE) begin
                        key_long[i] <= 1'b1;
                     end
                  end else begin
                     state[i]  <= REL_F;
                     db_cnt[i] <= '0;
                  end
               end
               REL_F: begin
                  if (pressed[i]) begin
                     state[i] <= DOWN;
                  end else if (db_cnt[i] == DB_LAST) begin
                     state[i]       <= IDLE;
                     db_cnt[i]      <= '0;
                     key_state[i]   <= 1'b0;
                     key_release[i] <= 1'b1;
                  end else begin
                     db_cnt[i] <= db_cnt[i] + DW'(1);
                  end
               end
               default: state[i] <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Self-checking bench for key_debounce_multi: vector table, timed corner-case
// sequences and randomized pin activity against a run-length reference model.
`timescale 1ns/1ps

module tb_key_debounce_multi;

   localparam int N = 4;
   localparam int D = 50;
   localparam int L = 200;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] key_in = '1;
   logic [N-1:0] key_state, key_press, key_release, key_long, led;

   int tests = 0;
   int fails = 0;
   bit monEn = 1'b0;

   int pressCount [N];
   int longCount  [N];
   int busyCount = 0;

   always #10 clk = ~clk;

   key_debounce_multi #(
      .N_KEYS(N), .DEBOUNCE_CYC(D), .LONG_CYC(L), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_in(key_in),
      .key_state(key_state), .key_press(key_press), .key_release(key_release),
      .key_long(key_long), .led(led)
   );

   // Reference model: a level is accepted once the synchronised sample has
   // disagreed with the accepted level for D consecutive samples; hold time is
   // the number of consecutive pressed-sample pairs seen while accepted.
   logic [N-1:0] mS1, mS2, mAcc, mPprev, mPress, mRel, mLong, mLed;
   int           mRun [N];
   int           mHold [N];

   always @(posedge clk or negedge rst_n) begin : model
      logic [N-1:0] acc, ld, pr, rl, lg;
      int           run, hold;
      logic         p;
      if (!rst_n) begin
         mS1    <= '1;
         mS2    <= '1;
         mAcc   <= '0;
         mPprev <= '0;
         mPress <= '0;
         mRel   <= '0;
         mLong  <= '0;
         mLed   <= '0;
         for (int i = 0; i < N; i++) begin
            mRun[i]  <= 0;
            mHold[i] <= 0;
         end
      end else begin
         acc = mAcc;
         ld  = mLed;
         pr  = '0;
         rl  = '0;
         lg  = '0;
         for (int i = 0; i < N; i++) begin
            p    = !mS2[i];
            run  = mRun[i];
            hold = mHold[i];
            if (acc[i] && p && mPprev[i] && hold < L) begin
               hold = hold + 1;
               if (hold == L) lg[i] = 1'b1;
            end
            if (p != acc[i]) begin
               run = run + 1;
               if (run == D) begin
                  acc[i] = p;
                  run    = 0;
                  if (p) begin
                     pr[i] = 1'b1;
                     ld[i] = !ld[i];
                     hold  = 0;
                  end else begin
                     rl[i] = 1'b1;
                  end
               end
            end else begin
               run = 0;
            end
            mRun[i]  <= run;
            mHold[i] <= hold;
         end
         mAcc   <= acc;
         mLed   <= ld;
         mPress <= pr;
         mRel   <= rl;
         mLong  <= lg;
         mPprev <= ~mS2;
         mS2    <= mS1;
         mS1    <= key_in;
      end
   end

   // Cycle-by-cycle comparison against the model plus event counters.
   always @(negedge clk) begin
      if (monEn) begin
         tests++;
         if ({key_state, key_press, key_release, key_long, led} !==
             {mAcc, mPress, mRel, mLong, mLed}) begin
            fails++;
            $display("[TB] FAIL model t=%0t got st/pr/rl/lg/led=%b/%b/%b/%b/%b expected %b/%b/%b/%b/%b",
                     $time, key_state, key_press, key_release, key_long, led,
                     mAcc, mPress, mRel, mLong, mLed);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (key_press[i]) pressCount[i]++;
         if (key_long[i])  longCount[i]++;
      end
      if (|{key_state, key_press, key_release, key_long, led}) busyCount++;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [N-1:0] pins);
      key_in = pins;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic doReset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   // Returns the negedge count at which the selected pulse appears, or -1.
   task automatic waitFor(input int sel, input int key, input int maxCyc, output int cyc);
      logic [N-1:0] v;
      cyc = -1;
      for (int c = 1; c <= maxCyc; c++) begin
         @(negedge clk);
         v = (sel == 0) ? key_press : (sel == 1) ? key_release : key_long;
         if (v[key]) begin
            cyc = c;
            break;
         end
      end
   endtask

   typedef struct {
      logic [N-1:0] pins;
      int           cycles;
      logic [N-1:0] expState;
      logic [N-1:0] expLed;
   } vec_t;

   vec_t vecs [8];

   initial begin : watchdog
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin : main
      int cyc, p0, pOthers, l0, b0;
      int cnt [N];

      vecs[0] = '{4'b1110, 100, 4'b0001, 4'b0001};
      vecs[1] = '{4'b1111, 100, 4'b0000, 4'b0001};
      vecs[2] = '{4'b0110, 100, 4'b1001, 4'b1000};
      vecs[3] = '{4'b1111, 100, 4'b0000, 4'b1000};
      vecs[4] = '{4'b1110,  40, 4'b0000, 4'b1000};
      vecs[5] = '{4'b1111,  10, 4'b0000, 4'b1000};
      vecs[6] = '{4'b1011, 100, 4'b0100, 4'b1100};
      vecs[7] = '{4'b1111, 100, 4'b0000, 4'b1100};

      for (int i = 0; i < N; i++) begin
         cnt[i] = 0;
      end

      key_in = '1;
      rst_n  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset outputs", 32'({key_state, key_press, key_release, key_long, led}), 32'd0);
      #2 rst_n = 1'b1;
      monEn = 1'b1;
      idle(5);

      // Single key press and release latency.
      applyStimulus(4'b1110);
      waitFor(0, 0, 100, cyc);
      checkOutput("s1 press latency", cyc, 52);
      checkOutput("s1 press mask", 32'(key_press), 32'b0001);
      @(negedge clk);
      checkOutput("s1 press width", 32'(key_press), 32'd0);
      idle(46);
      checkOutput("s1 key_state", 32'(key_state), 32'b0001);
      checkOutput("s1 led", 32'(led), 32'b0001);
      applyStimulus(4'b1111);
      waitFor(1, 0, 100, cyc);
      checkOutput("s1 release latency", cyc, 52);
      idle(60);

      // Bounce on press: only the final falling edge qualifies.
      p0      = pressCount[0];
      pOthers = pressCount[1] + pressCount[2] + pressCount[3];
      applyStimulus(4'b1110);
      idle(20);
      applyStimulus(4'b1111);
      idle(7);
      applyStimulus(4'b1110);
      waitFor(0, 0, 100, cyc);
      checkOutput("s2 press from last edge", cyc, 52);
      idle(60);
      checkOutput("s2 press count key0", pressCount[0] - p0, 1);
      checkOutput("s2 press count others", pressCount[1] + pressCount[2] + pressCount[3] - pOthers, 0);
      applyStimulus(4'b1111);
      idle(70);

      // Long press and release timing.
      l0 = longCount[0];
      applyStimulus(4'b1110);
      waitFor(0, 0, 100, cyc);
      checkOutput("s3 press latency", cyc, 52);
      waitFor(2, 0, 300, cyc);
      checkOutput("s3 long after press", cyc, 200);
      idle(48);
      applyStimulus(4'b1111);
      waitFor(1, 0, 100, cyc);
      checkOutput("s3 release latency", cyc, 52);
      idle(10);
      checkOutput("s3 long count", longCount[0] - l0, 1);

      // Simultaneous presses and LED toggling.
      doReset();
      applyStimulus(4'b0110);
      waitFor(0, 0, 100, cyc);
      checkOutput("s4 press latency", cyc, 52);
      checkOutput("s4 press mask", 32'(key_press), 32'b1001);
      idle(10);
      checkOutput("s4 led both", 32'(led), 32'b1001);
      applyStimulus(4'b1111);
      idle(70);
      applyStimulus(4'b1110);
      idle(60);
      checkOutput("s4 led key0 again", 32'(led), 32'b1000);
      applyStimulus(4'b1111);
      idle(70);

      // Reset while a key is held forces re-qualification.
      applyStimulus(4'b1011);
      waitFor(0, 2, 100, cyc);
      checkOutput("s5 first press", cyc, 52);
      idle(20);
      #2 rst_n = 1'b0;
      #1 checkOutput("s5 outputs at reset", 32'({key_state, key_press, key_release, key_long, led}), 32'd0);
      repeat (5) begin
         @(negedge clk);
         checkOutput("s5 outputs in reset", 32'({key_state, key_press, key_release, key_long, led}), 32'd0);
      end
      #2 rst_n = 1'b1;
      waitFor(0, 2, 100, cyc);
      checkOutput("s5 press after reset", cyc, 52);
      applyStimulus(4'b1111);
      idle(70);

      // Short glitches on every key produce nothing.
      doReset();
      b0 = busyCount;
      repeat (3) begin
         applyStimulus(4'b0000);
         idle(40);
         applyStimulus(4'b1111);
         idle(20);
      end
      idle(10);
      checkOutput("s6 busy cycles", busyCount - b0, 0);
      checkOutput("s6 key_state", 32'(key_state), 32'd0);

      // Vector table from a clean reset.
      doReset();
      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].pins);
         idle(vecs[v].cycles);
         checkOutput($sformatf("vec%0d key_state", v), 32'(key_state), 32'(vecs[v].expState));
         checkOutput($sformatf("vec%0d led", v), 32'(led), 32'(vecs[v].expLed));
      end

      // Randomized segment lengths per key, checked cycle by cycle by the model.
      doReset();
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (cnt[i] == 0) begin
               key_in[i] = ~key_in[i];
               cnt[i]    = int'($urandom_range(5, 260));
            end else begin
               cnt[i] = cnt[i] - 1;
            end
         end
         if ($urandom_range(0, 999) == 0) doReset();
      end
      idle(5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
